// File: rtl/music_player.sv
// Score sequencer: steps through {note, beats} entries in a ROM and drives a square-wave buzzer.
// Note period comes from an external lookup on hz_sel; each note is followed by a silent gap.
module music_player #(
    parameter int CLK_FRE  = 50_000_000,
    parameter int BEAT_CYC = 12_500_000,
    parameter int GAP_CYC  = 500_000,
    parameter int SCORE_AW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    output logic [SCORE_AW-1:0] rom_addr,
    input  logic [15:0]         rom_data,
    output logic [7:0]          hz_sel,
    input  logic [19:0]         cycle,
    output logic                buzzer,
    output logic                busy,
    output logic                done
);

    // Wide enough for 255 * BEAT_CYC and for GAP_CYC, so the note length never truncates.
    localparam int DUR_W = 8 + $clog2(BEAT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
    localparam logic [SCORE_AW-1:0] LAST_ADDR = '1;

    if (BEAT_CYC < 1 || GAP_CYC < 1 || CLK_FRE < 1) begin : g_bad_cfg
        $error("music_player: CLK_FRE, BEAT_CYC and GAP_CYC must be positive");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [SCORE_AW-1:0] addr_q, addr_d;
    logic [7:0]          note_q, note_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [19:0]         t_q, t_d;
    logic                done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            note_q  <= '0;
            cnt_q   <= '0;
            t_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        cnt_d   = cnt_q;
        t_d     = '0;
        done_d  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = FETCH;
                        addr_d  = '0;
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    note_d = rom_data[15:8];
                    if (rom_data[7:0] == 8'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PLAY;
                        cnt_d   = CNT_W'(rom_data[7:0]) * CNT_W'(BEAT_CYC) - CNT_W'(1);
                    end
                end
                PLAY: begin
                    // A zero period (rest) parks the tone counter at 0.
                    if (cycle != 20'd0 && t_q < cycle - 20'd1) begin
                        t_d = t_q + 20'd1;
                    end
                    if (cnt_q == '0) begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(GAP_CYC - 1);
                        t_d     = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        if (addr_q == LAST_ADDR) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FETCH;
                            addr_d  = addr_q + SCORE_AW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so an asynchronous reset silences them at once.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = done_q;
        rom_addr = addr_q;
        hz_sel   = (state_q == PLAY) ? note_q : 8'h00;
        buzzer   = (state_q == PLAY) && (t_q < {1'b0, cycle[19:1]});
    end

endmodule

// File: doc/music_player.md
MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BEAT_CYC, default 12_500_000, clock cycles per beat.
REQ-003 SHALL have parameter GAP_CYC, default 500_000, silent clock cycles inserted after every note.
REQ-004 SHALL have parameter SCORE_AW, default 8, score ROM address width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, request to play from address 0.
REQ-008 SHALL have port stop, input, 1, abort playback.
REQ-009 SHALL have port rom_addr, output, SCORE_AW, score entry address.
REQ-010 SHALL have port rom_data, input, 16, entry {note[15:8], beats[7:0]}, valid one clock after rom_addr.
REQ-011 SHALL have port hz_sel, output, 8, note code to the note-to-period lookup.
REQ-012 SHALL have port cycle, input, 20, tone period in clocks from the lookup; combinational from hz_sel; 0 = rest/unknown.
REQ-013 SHALL have port buzzer, output, 1, square-wave tone output.
REQ-014 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at normal end of score.

Function
REQ-016 SHALL implement states IDLE, FETCH, LOAD, PLAY, GAP; exactly one FETCH and one LOAD cycle per entry.
REQ-017 IDLE: start=1 and stop=0 -> FETCH with rom_addr=0; start while busy SHALL be ignored.
REQ-018 FETCH: one cycle, rom_addr stable -> LOAD.
REQ-019 LOAD: SHALL register rom_data into note/beats; beats==0 (terminator) -> IDLE with done=1 the following cycle; else -> PLAY.
REQ-020 hz_sel SHALL equal the registered note during PLAY and 8'h00 in all other states.
REQ-021 PLAY SHALL last exactly beats*BEAT_CYC cycles (beats 1..255, product width sufficient, no truncation) -> GAP.
REQ-022 GAP SHALL last exactly GAP_CYC cycles with buzzer=0; then rom_addr+1 -> FETCH, except rom_addr==2^SCORE_AW-1 -> IDLE with done pulse (no wrap to 0).
REQ-023 Tone: counter t SHALL run 0..cycle-1 during PLAY, cleared on PLAY entry; buzzer=1 when t < cycle>>1, else 0.
REQ-024 cycle==0 in PLAY (rest or unmapped code) SHALL hold t=0 and buzzer=0 for the full duration.
REQ-025 cycle==1 SHALL yield buzzer=0 constantly (cycle>>1 = 0).
REQ-026 buzzer SHALL be 0 outside PLAY.
REQ-027 stop=1 in any state SHALL force IDLE next cycle, buzzer=0, hz_sel=0, no done pulse; stop wins over simultaneous start.
REQ-028 done SHALL never coincide with busy=1 in the same cycle.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, rom_addr=0, hz_sel=8'h00, buzzer=0, busy=0, done=0, all counters 0.
REQ-030 rst asserted mid-PLAY SHALL silence buzzer immediately without waiting for a clock edge; after release, block waits in IDLE for start.

Verification (BEAT_CYC=10, GAP_CYC=2, SCORE_AW=4, lookup stub: 8'h11->cycle 8, 8'h05->cycle 5, else 0)
REQ-031 ROM[0]=16'h1102, ROM[1]=16'h0000; start pulse -> busy next cycle, hz_sel=8'h11 for 20 cycles, buzzer pattern 1111_0000 repeated 2.5 times, 2-cycle gap, done single pulse, busy=0.
REQ-032 ROM[0]=16'h0001 (rest), ROM[1]=0 -> buzzer 0 for 10 PLAY cycles, hz_sel=8'h00 throughout, done pulse.
REQ-033 ROM[0]=16'h0501 -> period 5: buzzer 11000 repeating for 10 cycles.
REQ-034 All 16 entries nonzero beats=1 -> 16 notes played, done after GAP of address 15, rom_addr never returns to 0 during play.
REQ-035 stop asserted at cycle 5 of PLAY -> IDLE next cycle, buzzer 0, done never asserts; start+stop same cycle in IDLE -> stays IDLE.
REQ-036 rst pulsed mid-PLAY between clock edges -> buzzer, busy, hz_sel 0 before next edge; new start plays from address 0.
